// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and defaults for the product-to-BCD converter
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    localparam int W_DEF    = 16;
    localparam int NDIG_DEF = 5;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - double-dabble add-3 correction for one BCD digit
module bcd_digit_adjust
    import booth_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/result_bcd_converter.sv
// rtl/result_bcd_converter.sv - sequential binary-to-BCD converter, signed mode under SIGNED_RESULT_EN
module result_bcd_converter
    import booth_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NDIG = NDIG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      Y,
    output logic              busy,
    output logic              done,
    output logic              neg,
    output logic [4*NDIG-1:0] digits
);

    localparam int CW = $clog2(W) + 1;

    state_t              state;
    logic [4*NDIG-1:0]   bcd_q;
    logic [4*NDIG-1:0]   bcd_adj;
    logic [W-1:0]        bin_q;
    logic [CW-1:0]       cnt_q;
    logic                sign_q;
    logic [W-1:0]        mag;
    logic                sign_in;
    logic [4*NDIG+W-1:0] shifted;

    // Magnitude is taken at capture so the shift loop only ever sees unsigned data.
`ifdef SIGNED_RESULT_EN
    assign mag     = Y[W-1] ? -Y : Y;
    assign sign_in = Y[W-1] & (mag != '0);
`else
    assign mag     = Y;
    assign sign_in = 1'b0;
`endif

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (bcd_q[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    assign shifted = {bcd_adj, bin_q} << 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            bcd_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            sign_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            neg    <= 1'b0;
            digits <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_q  <= mag;
                        sign_q <= sign_in;
                        bcd_q  <= '0;
                        cnt_q  <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= shifted;
                    cnt_q          <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    digits <= bcd_q;
                    neg    <= sign_q;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// tb/tb_result_bcd_converter.sv - directed self-checking bench for result_bcd_converter
module tb_result_bcd_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] Y = '0;
    logic        busy;
    logic        done;
    logic        neg;
    logic [19:0] digits;

    int nvec = 0;
    int nerr = 0;

    result_bcd_converter #(.W(16), .NDIG(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .Y      (Y),
        .busy   (busy),
        .done   (done),
        .neg    (neg),
        .digits (digits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts a conversion and checks latency, digits and sign.
    task automatic run(input logic [15:0] y, input logic [19:0] exp_dig, input logic exp_neg, input string tag);
        int n;
        @(negedge clk);
        Y     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 32'd17);
        check({tag, "_digits"}, {12'd0, digits}, {12'd0, exp_dig});
        check({tag, "_neg"}, {31'd0, neg}, {31'd0, exp_neg});
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int ndone;
        int first_done;
        logic held_ok;

        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_neg", {31'd0, neg}, 32'd0);
        check("rst_digits", {12'd0, digits}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run(16'h0000, 20'h00000, 1'b0, "zero");
        run(16'h3039, 20'h12345, 1'b0, "d12345");
`ifdef SIGNED_RESULT_EN
        run(16'hC080, 20'h16256, 1'b1, "neg16256");
        run(16'h8000, 20'h32768, 1'b1, "min_neg");
        run(16'hFFFF, 20'h00001, 1'b1, "minus_one");
`else
        run(16'hFFFF, 20'h65535, 1'b0, "max_unsigned");
        run(16'h8000, 20'h32768, 1'b0, "u32768");
        run(16'hC080, 20'h49280, 1'b0, "u49280");
`endif
        run(16'd9, 20'h00009, 1'b0, "d9");

        // Y=100 with a second start at cycle 5 that must be ignored.
        @(negedge clk);
        Y     = 16'd100;
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        n          = 0;
        ndone      = 0;
        first_done = -1;
        held_ok    = 1'b1;
        while (n < 40) begin
            if (n == 5) begin
                Y     = 16'd999;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = n;
            end else if (ndone == 0 && digits !== 20'h00009) begin
                held_ok = 1'b0;
            end
        end
        check("ign_done_count", ndone, 32'd1);
        check("ign_latency", first_done, 32'd17);
        check("ign_held", {31'd0, held_ok}, 32'd1);
        check("ign_digits", {12'd0, digits}, 32'h00100);

        // Reset partway through a conversion.
        @(negedge clk);
        Y     = 16'h3039;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_digits", {12'd0, digits}, 32'd0);
        check("mid_rst_neg", {31'd0, neg}, 32'd0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_rst_no_done", ndone, 32'd0);
        check("mid_rst_idle", {31'd0, busy}, 32'd0);
        run(16'd7, 20'h00007, 1'b0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
